shift_sequencer: RTL and testbench

- Multi-cycle variable-amount shifter controller.
- Accepts an operand and a shift amount.
- Drives a single one-position shift stage once per cycle until the requested amount is reached, then presents the result with a one-cycle done pulse.
- Sits between the ALU control path and the one-bit shift datapath, so that barrel-shifter area is replaced by iteration.

---
 rtl/shift_seq_pkg.sv | 22 ++
 rtl/mux2x1.sv | 11 +
 rtl/shift_seq_shift1_lr.sv | 37 +++
 rtl/shift_sequencer.sv | 126 ++++++++++++
 tb/tb_shift_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the iterative shift sequencer.
// Arithmetic right shift support is enabled by defining SHIFT_SEQ_ARITH_EN.
package shift_seq_pkg;

    localparam int unsigned N_DEFAULT   = 8;
    localparam int unsigned SHW_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Bit shifted into the vacated position: sign bit only for arithmetic right shifts.
    function automatic logic fill_bit(input logic dir, input logic arith, input logic msb);
        return ((dir == DIR_RIGHT) && arith) ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/mux2x1.sv
// Library 2:1 multiplexer cell: y = sel ? in1 : in0.
module mux2x1 (
    input  logic in0,
    input  logic in1,
    input  logic sel,
    output logic y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/shift_seq_shift1_lr.sv
// One-position left/right shift stage, one mux2x1 per bit.
// The vacated bit (LSB on left shift, MSB on right shift) takes the fill input.
module shift1_lr #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] data,
    input  logic         dir,
    input  logic         fill,
    output logic [N-1:0] q
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic lsrc;
        logic rsrc;

        if (i == 0) begin : g_lsb
            assign lsrc = fill;
        end else begin : g_lmid
            assign lsrc = data[i-1];
        end

        if (i == N - 1) begin : g_msb
            assign rsrc = fill;
        end else begin : g_rmid
            assign rsrc = data[i+1];
        end

        // dir=0 selects the left-shift source, dir=1 the right-shift source
        mux2x1 u_mux (
            .in0 (lsrc),
            .in1 (rsrc),
            .sel (dir),
            .y   (q[i])
        );
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable-amount shifter: one single-bit shift per cycle, then a done pulse.
// Define SHIFT_SEQ_ARITH_EN to add the arith port (arithmetic right shifts).
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned N   = N_DEFAULT,
    parameter int unsigned SHW = SHW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   din,
    input  logic [SHW-1:0] shamt,
    input  logic           dir,
`ifdef SHIFT_SEQ_ARITH_EN
    input  logic           arith,
`endif
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   dout
);

    state_t         state, state_next;
    logic [N-1:0]   work, work_next;
    logic [SHW-1:0] count, count_next;
    logic           dir_q, dir_next;
    logic           arith_q, arith_next;
    logic           busy_next;
    logic           done_next;
    logic [N-1:0]   dout_next;
    logic           fill_c;
    logic [N-1:0]   shifted_c;

`ifdef SHIFT_SEQ_ARITH_EN
    logic arith_in_c;
    assign arith_in_c = arith;
`else
    logic arith_in_c;
    assign arith_in_c = 1'b0;
`endif

    assign fill_c = fill_bit(dir_q, arith_q, work[N-1]);

    shift1_lr #(
        .N (N)
    ) u_shift1 (
        .data (work),
        .dir  (dir_q),
        .fill (fill_c),
        .q    (shifted_c)
    );

    // State, operand and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            work    <= '0;
            count   <= '0;
            dir_q   <= DIR_LEFT;
            arith_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
        end else begin
            state   <= state_next;
            work    <= work_next;
            count   <= count_next;
            dir_q   <= dir_next;
            arith_q <= arith_next;
            busy    <= busy_next;
            done    <= done_next;
            dout    <= dout_next;
        end
    end

    // Next-state and registered-output decode; busy/done/dout reflect the state being entered
    always_comb begin
        state_next = state;
        work_next  = work;
        count_next = count;
        dir_next   = dir_q;
        arith_next = arith_q;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        dout_next  = dout;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    work_next  = din;
                    count_next = shamt;
                    dir_next   = dir;
                    arith_next = arith_in_c;
                    busy_next  = 1'b1;
                    if (shamt != '0) begin
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        dout_next  = din;
                    end
                end
            end

            ST_SHIFT: begin
                work_next  = shifted_c;
                count_next = count - SHW'(1);
                busy_next  = 1'b1;
                if (count == SHW'(1)) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                    dout_next  = shifted_c;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (N=8, SHW=3).
// Arithmetic cases run only when SHIFT_SEQ_ARITH_EN is defined.
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic [2:0] shamt;
    logic       dir;
    logic       arith;
    logic       busy;
    logic       done;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(
        .N   (8),
        .SHW (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .shamt (shamt),
        .dir   (dir),
`ifdef SHIFT_SEQ_ARITH_EN
        .arith (arith),
`endif
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then watch for done; checks latency, busy length and result.
    task automatic do_op(input logic [7:0] d, input logic [2:0] s, input logic dr,
                         input logic ar, input logic [7:0] exp, input string tag);
        int lat;
        int busy_cnt;
        bit got;
        lat      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        @(negedge clk);
        din   = d;
        shamt = s;
        dir   = dr;
        arith = ar;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                got = 1'b1;
                lat = c;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(s) + 32'd1);
        check({tag, "_dout"}, 32'(dout), 32'(exp));
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'(s) + 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int lat;
        rst   = 1'b0;
        start = 1'b0;
        din   = '0;
        shamt = '0;
        dir   = 1'b0;
        arith = 1'b0;

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dout", 32'(dout), 32'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'hB3, 3'd3, 1'b0, 1'b0, 8'h98, "left3");

        // Right shift with a start re-pulse while busy
        done_cnt = 0;
        lat      = 0;
        @(negedge clk);
        din   = 8'hB3;
        shamt = 3'd3;
        dir   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("lock_busy_c1", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("lock_dout_hold", 32'(dout), 32'h98);
        din   = 8'hFF;
        shamt = 3'd0;
        dir   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (done === 1'b1) done_cnt++;
        for (int c = 4; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                lat = c;
            end
            if (c == 4) check("lock_dout", 32'(dout), 32'h16);
        end
        check("lock_done_count", 32'(done_cnt), 32'd1);
        check("lock_latency", 32'(lat), 32'd4);
        check("lock_dout_final", 32'(dout), 32'h16);

        do_op(8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, "zero");
        do_op(8'hFF, 3'd7, 1'b0, 1'b0, 8'h80, "left7");
        do_op(8'hFF, 3'd7, 1'b1, 1'b0, 8'h01, "right7");

        // Abort mid-SHIFT with reset
        @(negedge clk);
        din   = 8'h0F;
        shamt = 3'd5;
        dir   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy_pre", 32'(busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dout", 32'(dout), 32'h00);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_dout_hold", 32'(dout), 32'h00);
        do_op(8'h0F, 3'd2, 1'b0, 1'b0, 8'h3C, "after_abort");

`ifdef SHIFT_SEQ_ARITH_EN
        do_op(8'h90, 3'd2, 1'b1, 1'b1, 8'hE4, "arith_on");
        do_op(8'h90, 3'd2, 1'b1, 1'b0, 8'h24, "arith_off");
        do_op(8'h90, 3'd2, 1'b0, 1'b1, 8'h40, "arith_left");
`else
        do_op(8'h90, 3'd2, 1'b1, 1'b0, 8'h24, "logical_right");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog against a hung simulation
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
